// File: rtl/melody_chime_pkg.sv
// rtl/melody_chime_pkg.sv - shared widths and constants for the melody chime tone block
// Contents: slot count/width defaults, divider/envelope/wave widths,
//   mid-scale helper for the unsigned PCM output.
package melody_chime_pkg;

  localparam int SLOT_W_DEFAULT   = 1;
  localparam int SLOT_LEN_DEFAULT = 2 ** SLOT_W_DEFAULT;

  localparam int DIV_W  = 8;
  localparam int ENV_W  = 8;
  // One extra bit so +ENV and -ENV are both representable.
  localparam int WAVE_W = ENV_W + 1;

  // Unsigned offset that centres the signed slot mix.
  function automatic int mid_scale(input int slot_w);
    return 1 << (slot_w + ENV_W);
  endfunction

endpackage

// File: rtl/melody_chime_slot_osc.sv
// rtl/melody_chime_slot_osc.sv - one square-wave slot with decaying envelope
// Ports: clk/rst_n clock and async active-low reset, tone_tick 50 kHz enable,
//   env_tick 1 ms enable, wr_en/note/divs slot write, wave signed slot output,
//   env current envelope.
module melody_chime_slot_osc
  import melody_chime_pkg::*;
#(
  parameter int C_DECAY_SHIFT = 4,
  parameter int C_ENV_INIT    = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tone_tick,
  input  logic                     env_tick,
  input  logic                     wr_en,
  input  logic                     note,
  input  logic [DIV_W-1:0]         divs,
  output logic signed [WAVE_W-1:0] wave,
  output logic [ENV_W-1:0]         env
);

  localparam logic [ENV_W-1:0] ENV_INIT_V = ENV_W'(C_ENV_INIT);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] ctr_q;
  logic             phase_q;
  logic [ENV_W-1:0] env_q;

  logic [DIV_W-1:0] ctr_dec;
  logic [ENV_W-1:0] decay_step;

  assign ctr_dec = ctr_q - 1'b1;

  // Proportional decay, but never stall once the envelope is small.
  always_comb begin
    decay_step = env_q >> C_DECAY_SHIFT;
    if (decay_step == '0) begin
      decay_step = ENV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      ctr_q   <= '0;
      phase_q <= 1'b0;
      env_q   <= '0;
    end else if (wr_en) begin
      // A write owns the slot for this cycle; a sustain write leaves it untouched.
      if (note) begin
        if (divs != '0) begin
          div_q   <= divs;
          ctr_q   <= divs;
          phase_q <= 1'b1;
          env_q   <= ENV_INIT_V;
        end else begin
          env_q <= '0;
        end
      end
    end else begin
      if (tone_tick) begin
        if (ctr_q == '0) begin
          ctr_q   <= div_q;
          phase_q <= 1'b1;
        end else begin
          ctr_q <= ctr_dec;
          if (ctr_dec == (div_q >> 1)) begin
            phase_q <= 1'b0;
          end
        end
      end
      // env_q >= decay_step whenever env_q != 0, so no underflow.
      if (env_tick && (env_q != '0)) begin
        env_q <= env_q - decay_step;
      end
    end
  end

  assign wave = phase_q ? {1'b0, env_q} : -{1'b0, env_q};
  assign env  = env_q;

endmodule

// File: rtl/melody_chime_slot_tone.sv
// rtl/melody_chime_slot_tone.sv - per-slot tone generators mixed into one PCM sample
// Ports: CK_i clock, XAR_i async active-low reset, TIMING_50k_i tone enable,
//   TIMING_1ms_i envelope enable, SLOT_divs_i/SLOT_note_i write data,
//   SLOTs_WT_REQ_i one-hot per-slot write strobe, PCM_o unsigned mixed sample,
//   SLOTs_ENV_o per-slot envelopes (slot 0 in LSBs), SLOTs_BUSY_o envelope non-zero.
module melody_chime_slot_tone
  import melody_chime_pkg::*;
#(
  parameter int C_SLOT_W      = SLOT_W_DEFAULT,
  parameter int C_DECAY_SHIFT = 4,
  parameter int C_ENV_INIT    = 255
) (
  input  logic                              CK_i,
  input  logic                              XAR_i,
  input  logic                              TIMING_50k_i,
  input  logic                              TIMING_1ms_i,
  input  logic [DIV_W-1:0]                  SLOT_divs_i,
  input  logic                              SLOT_note_i,
  input  logic [(2**C_SLOT_W)-1:0]          SLOTs_WT_REQ_i,
  output logic [C_SLOT_W+8:0]               PCM_o,
  output logic [ENV_W*(2**C_SLOT_W)-1:0]    SLOTs_ENV_o,
  output logic [(2**C_SLOT_W)-1:0]          SLOTs_BUSY_o
);

  localparam int               C_SLOT_LEN = 2 ** C_SLOT_W;
  localparam int               SUM_W      = C_SLOT_W + WAVE_W;
  localparam logic [SUM_W-1:0] MID        = SUM_W'(mid_scale(C_SLOT_W));

  logic [WAVE_W-1:0] slot_wave [C_SLOT_LEN];
  logic [ENV_W-1:0]  slot_env  [C_SLOT_LEN];
  logic [SUM_W-1:0]  wave_sum;

  for (genvar gi = 0; gi < C_SLOT_LEN; gi++) begin : g_slot
    melody_chime_slot_osc #(
      .C_DECAY_SHIFT (C_DECAY_SHIFT),
      .C_ENV_INIT    (C_ENV_INIT)
    ) u_osc (
      .clk       (CK_i),
      .rst_n     (XAR_i),
      .tone_tick (TIMING_50k_i),
      .env_tick  (TIMING_1ms_i),
      .wr_en     (SLOTs_WT_REQ_i[gi]),
      .note      (SLOT_note_i),
      .divs      (SLOT_divs_i),
      .wave      (slot_wave[gi]),
      .env       (slot_env[gi])
    );

    assign SLOTs_ENV_o[gi*ENV_W +: ENV_W] = slot_env[gi];
    assign SLOTs_BUSY_o[gi]               = |slot_env[gi];
  end

  // Sign-extend each two's-complement wave; the sum cannot overflow SUM_W bits.
  always_comb begin
    wave_sum = '0;
    for (int i = 0; i < C_SLOT_LEN; i++) begin
      wave_sum = wave_sum + {{C_SLOT_W{slot_wave[i][WAVE_W-1]}}, slot_wave[i]};
    end
  end

  always_ff @(posedge CK_i or negedge XAR_i) begin
    if (!XAR_i) begin
      PCM_o <= MID;
    end else begin
      PCM_o <= wave_sum + MID;
    end
  end

endmodule

// File: tb/tb_melody_chime_slot_tone.sv
// tb/tb_melody_chime_slot_tone.sv - self-checking bench for melody_chime_slot_tone
module tb_melody_chime_slot_tone;

  localparam int NS  = 2;
  localparam int MID = 512;

  logic        CK_i = 1'b0;
  logic        XAR_i = 1'b0;
  logic        TIMING_50k_i = 1'b0;
  logic        TIMING_1ms_i = 1'b0;
  logic [7:0]  SLOT_divs_i = '0;
  logic        SLOT_note_i = 1'b0;
  logic [1:0]  SLOTs_WT_REQ_i = '0;
  logic [9:0]  PCM_o;
  logic [15:0] SLOTs_ENV_o;
  logic [1:0]  SLOTs_BUSY_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: envelope value, divider and position within the tone period.
  int m_env [NS];
  int m_div [NS];
  int m_pos [NS];
  int m_pcm;

  always #5 CK_i = ~CK_i;

  melody_chime_slot_tone dut (
    .CK_i           (CK_i),
    .XAR_i          (XAR_i),
    .TIMING_50k_i   (TIMING_50k_i),
    .TIMING_1ms_i   (TIMING_1ms_i),
    .SLOT_divs_i    (SLOT_divs_i),
    .SLOT_note_i    (SLOT_note_i),
    .SLOTs_WT_REQ_i (SLOTs_WT_REQ_i),
    .PCM_o          (PCM_o),
    .SLOTs_ENV_o    (SLOTs_ENV_o),
    .SLOTs_BUSY_o   (SLOTs_BUSY_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_env[i] = 0;
      m_div[i] = 0;
      m_pos[i] = 0;
    end
    m_pcm = MID;
  endfunction

  // High for the first (div - div/2) ticks of each (div+1)-tick period.
  function automatic int model_mix();
    int s;
    bit high;
    s = MID;
    for (int i = 0; i < NS; i++) begin
      high = (m_div[i] == 0) || (m_pos[i] < (m_div[i] - m_div[i] / 2));
      s += high ? m_env[i] : -m_env[i];
    end
    return s;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".pcm"}, 32'(PCM_o), 32'(m_pcm));
    for (int i = 0; i < NS; i++) begin
      check($sformatf("%s.env%0d", tag, i), 32'(SLOTs_ENV_o[8*i +: 8]), 32'(m_env[i]));
      check($sformatf("%s.busy%0d", tag, i), 32'(SLOTs_BUSY_o[i]), 32'(m_env[i] != 0));
    end
  endtask

  task automatic step(input bit t50, input bit t1, input logic [1:0] req,
                      input bit note, input int divs, input string tag);
    int mix_prev;
    int dec;
    TIMING_50k_i   = t50;
    TIMING_1ms_i   = t1;
    SLOTs_WT_REQ_i = req;
    SLOT_note_i    = note;
    SLOT_divs_i    = 8'(divs);
    mix_prev = model_mix();
    @(posedge CK_i);
    #1;
    m_pcm = mix_prev;
    for (int i = 0; i < NS; i++) begin
      if (req[i]) begin
        if (note) begin
          if (divs != 0) begin
            m_div[i] = divs;
            m_pos[i] = 0;
            m_env[i] = 255;
          end else begin
            m_env[i] = 0;
          end
        end
      end else begin
        if (t50) m_pos[i] = (m_pos[i] + 1) % (m_div[i] + 1);
        if (t1 && m_env[i] > 0) begin
          dec = m_env[i] / 16;
          if (dec < 1) dec = 1;
          m_env[i] -= dec;
        end
      end
    end
    TIMING_50k_i   = 1'b0;
    TIMING_1ms_i   = 1'b0;
    SLOTs_WT_REQ_i = '0;
    SLOT_note_i    = 1'b0;
    SLOT_divs_i    = '0;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 2'b00, 1'b0, 0, tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, 2'b00, 1'b0, 0, tag);
  endtask

  initial begin
    bit         r50, r1, rnote;
    logic [1:0] rreq;
    int         rdiv;
    int         n;

    // 1. reset state
    model_reset();
    #12;
    check("rst.pcm", 32'(PCM_o), 32'(MID));
    check("rst.env", 32'(SLOTs_ENV_o), 32'd0);
    check("rst.busy", 32'(SLOTs_BUSY_o), 32'd0);
    XAR_i = 1'b1;
    for (int k = 0; k < 4; k++) idle("post_rst");
    check("post_rst_mid", 32'(PCM_o), 32'(MID));

    // 2. note-on slot 0, period 64 ticks
    step(1'b0, 1'b0, 2'b01, 1'b1, 63, "note0");
    idle("note0_lat");
    check("note0_high", 32'(PCM_o), 32'd767);
    ticks(32, "tone0");
    idle("tone0_h");
    check("note0_low", 32'(PCM_o), 32'd257);
    ticks(32, "tone0b");
    idle("tone0b_h");
    check("note0_period", 32'(PCM_o), 32'd767);

    // 3. envelope decay to zero
    step(1'b0, 1'b0, 2'b01, 1'b1, 63, "decay_on");
    step(1'b0, 1'b1, 2'b00, 1'b0, 0, "decay1");
    check("decay_240", 32'(SLOTs_ENV_o[7:0]), 32'd240);
    step(1'b0, 1'b1, 2'b00, 1'b0, 0, "decay2");
    check("decay_225", 32'(SLOTs_ENV_o[7:0]), 32'd225);
    step(1'b0, 1'b1, 2'b00, 1'b0, 0, "decay3");
    check("decay_211", 32'(SLOTs_ENV_o[7:0]), 32'd211);
    step(1'b0, 1'b1, 2'b00, 1'b0, 0, "decay4");
    check("decay_198", 32'(SLOTs_ENV_o[7:0]), 32'd198);
    n = 0;
    while (SLOTs_BUSY_o[0] && n < 300) begin
      step(1'b0, 1'b1, 2'b00, 1'b0, 0, "decay_run");
      n++;
    end
    check("decay_busy_fall", 32'(SLOTs_BUSY_o[0]), 32'd0);
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 2'b00, 1'b0, 0, "decay_hold");
    check("decay_stays_zero", 32'(SLOTs_ENV_o[7:0]), 32'd0);

    // 4. sustain leaves slot alone, retrigger reloads
    step(1'b0, 1'b0, 2'b01, 1'b1, 63, "sus_on");
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 2'b00, 1'b0, 0, "sus_decay");
    step(1'b0, 1'b0, 2'b01, 1'b0, 127, "sus_write");
    check("sus_env", 32'(SLOTs_ENV_o[7:0]), 32'd211);
    ticks(32, "sus_tone");
    idle("sus_h");
    check("sus_div_kept", 32'(PCM_o), 32'd301);
    step(1'b0, 1'b0, 2'b01, 1'b1, 127, "retrig");
    check("retrig_env", 32'(SLOTs_ENV_o[7:0]), 32'd255);
    ticks(63, "retrig_tone");
    idle("retrig_h");
    check("retrig_still_high", 32'(PCM_o), 32'd767);
    ticks(1, "retrig_edge");
    idle("retrig_h2");
    check("retrig_low", 32'(PCM_o), 32'd257);
    ticks(64, "retrig_tone2");
    idle("retrig_h3");
    check("retrig_period", 32'(PCM_o), 32'd767);

    // 5. two slots mixed
    step(1'b0, 1'b0, 2'b10, 1'b1, 127, "two_s1");
    step(1'b0, 1'b0, 2'b01, 1'b1, 63, "two_s0");
    idle("two_h");
    check("two_both_high", 32'(PCM_o), 32'd1022);
    ticks(32, "two_tone");
    idle("two_h2");
    check("two_cancel", 32'(PCM_o), 32'd512);

    // 6. collision and rest
    step(1'b1, 1'b1, 2'b01, 1'b1, 50, "collide");
    check("collide_env", 32'(SLOTs_ENV_o[7:0]), 32'd255);
    step(1'b0, 1'b0, 2'b11, 1'b1, 0, "rest");
    check("rest_env", 32'(SLOTs_ENV_o), 32'd0);
    idle("rest_h");
    check("rest_mid", 32'(PCM_o), 32'd512);

    // 7. randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      r50   = ($urandom_range(0, 2) == 0);
      r1    = ($urandom_range(0, 19) == 0);
      rreq  = 2'b00;
      rnote = 1'b0;
      rdiv  = 0;
      if ($urandom_range(0, 14) == 0) begin
        rreq  = 2'($urandom_range(1, 3));
        rnote = ($urandom_range(0, 3) != 0);
        rdiv  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
        if (!rnote) begin
          r50 = 1'b0;
          r1  = 1'b0;
        end
      end
      step(r50, r1, rreq, rnote, rdiv, "rand");
    end

    // 8. asynchronous reset mid-note
    step(1'b0, 1'b0, 2'b11, 1'b1, 90, "mid_on");
    ticks(10, "mid_tone");
    #2;
    XAR_i = 1'b0;
    #1;
    model_reset();
    check("mid_rst.pcm", 32'(PCM_o), 32'(MID));
    check("mid_rst.env", 32'(SLOTs_ENV_o), 32'd0);
    check("mid_rst.busy", 32'(SLOTs_BUSY_o), 32'd0);
    #1;
    XAR_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'b00, 1'b0, 0, "after_rst");
    end
    check("after_rst_mid", 32'(PCM_o), 32'(MID));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/melody_chime_slot_tone.md
Name: melody_chime_slot_tone

Overview:
Tone-generator end of the melody-chime slot-write interface. It accepts per-slot write requests carrying an 8-bit divider and a note-on flag. For each slot it produces a square wave with an exponentially decaying envelope, then mixes all slots into one unsigned PCM sample for the DAC/PWM stage. It sits directly downstream of the score sequencer and shares its 1 ms timing strobe.

Parameters:
C_SLOT_W, 1, slot index width; slot count C_SLOT_LEN = 2**C_SLOT_W
C_DECAY_SHIFT, 4, envelope decay per 1 ms step is ENV>>C_DECAY_SHIFT (minimum 1)
C_ENV_INIT, 255, envelope value loaded on note-on (8-bit)

Ports:
CK_i  in  1  system clock
XAR_i  in  1  asynchronous reset, active low
TIMING_50k_i  in  1  tone clock enable, 1-cycle pulse at nominal 50 kHz
TIMING_1ms_i  in  1  envelope clock enable, 1-cycle pulse every 1 ms
SLOT_divs_i  in  8  divider code; tone period = SLOT_divs_i+1 ticks of TIMING_50k_i
SLOT_note_i  in  1  1 = note-on (retrigger), 0 = sustain (no change)
SLOTs_WT_REQ_i  in  C_SLOT_LEN  one-hot 1-cycle write strobe per slot; data valid in the same cycle
PCM_o  out  C_SLOT_W+9  unsigned mixed sample, mid-scale 2**(C_SLOT_W+8)
SLOTs_ENV_o  out  8*C_SLOT_LEN  per-slot envelope, slot 0 in the LSBs (debug/visualisation)
SLOTs_BUSY_o  out  C_SLOT_LEN  1 while the slot envelope is non-zero

Behaviour:
- Reset is asynchronous and active low on XAR_i. Every per-slot register (DIVs, DIV_CTR, PHASE, ENV) resets to 0. PCM_o resets to mid-scale (512 for C_SLOT_W=1). SLOTs_ENV_o and SLOTs_BUSY_o reset to 0.
- Write, per slot i, when SLOTs_WT_REQ_i[i]=1:
  - SLOT_note_i=1 and SLOT_divs_i!=0: DIVs<=SLOT_divs_i, DIV_CTR<=SLOT_divs_i, PHASE<=1, ENV<=C_ENV_INIT. Takes effect on the next clock.
  - SLOT_note_i=1 and SLOT_divs_i==0 (rest/unknown code): ENV<=0. DIVs unchanged.
  - SLOT_note_i=0: no state change (tie/sustain).
  - More than one bit set: each flagged slot is written independently with the same data.
- Tone, on TIMING_50k_i with no write to that slot:
  - DIV_CTR==0: DIV_CTR<=DIVs.
  - Otherwise DIV_CTR<=DIV_CTR-1.
  - PHASE<=1 when the reloaded value is loaded. PHASE<=0 when DIV_CTR-1 equals DIVs>>1.
  - Result: high for the first half of the period (DIVs-DIVs>>1 ticks), low for the rest.
  - DIVs==0 holds DIV_CTR at 0 and PHASE at 1.
- Envelope, on TIMING_1ms_i with no write to that slot:
  - ENV!=0: ENV<=ENV-max(ENV>>C_DECAY_SHIFT,1).
  - ENV==0: stays 0.
  - The result never underflows.
- Priority: write beats both the tone tick and the decay tick in the same cycle. The tone tick and the decay tick may coincide; both apply.
- Slot wave is a 9-bit signed value: PHASE ? +ENV : -ENV.
- Mix: signed sum of all slot waves, width C_SLOT_W+9, plus mid-scale offset. Registered into PCM_o one cycle after the slot registers change, so latency from write strobe to PCM_o is 2 clocks. No saturation is required; the range is provably within bounds (2..1022 for 2 slots).
- SLOTs_BUSY_o[i] = (ENV!=0), combinational from the slot register.
- A reset asserted mid-note silences all slots immediately. After release, PCM_o stays at mid-scale until the next note-on.

Decomposition:
- Shared package melody_chime_pkg: slot count/width, divider width (8), envelope width (8), mid-scale constant. The divider code table is not part of this block's scope; it stays with the sequencer.
- One natural sub-module: melody_chime_slot_osc, one per slot in a generate loop. It holds DIVs, DIV_CTR, PHASE and ENV, and outputs the signed wave and ENV. The top holds the mixer and output register.

Test Plan:
1. Reset: hold XAR_i low mid-activity -> PCM_o=512, SLOTs_ENV_o=0, SLOTs_BUSY_o=0 asynchronously; all remain so after release with no writes.
2. Note-on slot 0, divs=63, note=1 -> 2 clocks later PCM_o=512+255=767. After 32 TIMING_50k_i pulses PCM_o=512-255=257. Period repeats every 64 pulses.
3. Decay: after the item-2 note-on, apply 1 ms strobes only -> ENV sequence 255,240,225,211,198…, reaching 0 and staying 0. SLOTs_BUSY_o[0] falls at 0.
4. Sustain vs retrigger: write note=0, divs=127 to a decaying slot -> DIVs and ENV unchanged. Write note=1, divs=127 -> ENV=255, period becomes 128 ticks.
5. Two slots: slot0 divs=63, slot1 divs=127, both note-on, both PHASE=1 -> PCM_o=1022. With slot0 low and slot1 high -> PCM_o=512.
6. Collision and rest: write in the same cycle as TIMING_50k_i and TIMING_1ms_i -> write wins (ENV=255, DIV_CTR=divs). Write note=1, divs=0 -> ENV=0, PCM_o returns to 512 two clocks later.
